// File: rtl/adc_stim_gen.sv
// adc_stim_gen: multi-channel ADC response model.
// Emits one sample every PERIOD_CYCLES enabled clocks, round-robin across
// NUM_CH channels, with a selectable data pattern (count, ramp, LFSR, const).
//
// Handshake: response_valid_out is a one-cycle strobe with no ready/backpressure.
// On the cycle it is high, response_channel_out and ADC_out carry the sample.
// Between strobes both outputs hold the last sample. The consumer must take
// every strobe.
module adc_stim_gen #(
  parameter int                DATA_W        = 12,
  parameter int                NUM_CH        = 4,
  parameter int                PERIOD_CYCLES = 2000,
  parameter int                NOISE_W       = 5,
  parameter logic [DATA_W-1:0] BASE          = 12'h8C0,
  localparam int               CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] step,
  output logic              response_valid_out,
  output logic [CH_W-1:0]   response_channel_out,
  output logic [DATA_W-1:0] ADC_out
);

  localparam int                CNT_W      = $clog2(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CH_W-1:0]   PTR_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] NOISE_MASK = {DATA_W{1'b1}} >> (DATA_W - NOISE_W);
  localparam logic [DATA_W-1:0] BASE_CLR   = BASE & ~NOISE_MASK;
  localparam logic [15:0]       LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NOISE_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] acc_q [NUM_CH];
  logic [DATA_W-1:0] acc_d [NUM_CH];
  logic [15:0]       lfsr_q, lfsr_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              emit;
  logic [DATA_W-1:0] ramp_sum;
  logic [DATA_W-1:0] sample;
  logic              lfsr_fb;

  // Next-state: period timer, sample pattern selection and per-sample bookkeeping.
  always_comb begin
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    n_d      = n_q;
    acc_d    = acc_q;
    lfsr_d   = lfsr_q;
    valid_d  = 1'b0;
    ch_d     = ch_q;
    data_d   = data_q;
    sample   = '0;

    emit     = enable && (cnt_q == CNT_LAST);
    ramp_sum = acc_q[ptr_q] + step;
    // Fibonacci taps 16,14,13,11 in right-shift form: bits 0,2,3,5 feed bit 15.
    lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // Dropping enable clears the timer, so a re-enable always waits a full period.
    if (!enable || emit) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;

    case (mode_e'(mode))
      MODE_COUNT: sample = BASE_CLR | (DATA_W'(n_q) & NOISE_MASK);
      MODE_RAMP:  sample = ramp_sum;
      MODE_LFSR:  sample = BASE_CLR | (DATA_W'(lfsr_q) & NOISE_MASK);
      MODE_CONST: sample = BASE_CLR | (DATA_W'(ptr_q) & NOISE_MASK);
      default:    sample = BASE_CLR;
    endcase

    if (emit) begin
      valid_d = 1'b1;
      ch_d    = ptr_q;
      data_d  = sample;
      if (mode_e'(mode) == MODE_RAMP) acc_d[ptr_q] = ramp_sum;
      n_d     = n_q + 1'b1;
      lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
      ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      ptr_q   <= '0;
      n_q     <= '0;
      lfsr_q  <= LFSR_SEED;
      valid_q <= 1'b0;
      ch_q    <= '0;
      data_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      n_q     <= n_d;
      lfsr_q  <= lfsr_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign response_valid_out   = valid_q;
  assign response_channel_out = ch_q;
  assign ADC_out              = data_q;

endmodule

// File: tb/tb_adc_stim_gen.sv
// Bench for adc_stim_gen: random and directed sample sequences checked by a
// queue-based scoreboard fed from a sample-order reference model.
module tb_adc_stim_gen;

  localparam int P   = 20;
  localparam int DW  = 12;
  localparam int NCH = 4;
  localparam int NW  = 5;
  localparam int CHW = 2;
  localparam logic [DW-1:0] BASE_CLR = 12'h8C0 & ~12'h01F;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [1:0]    mode;
  logic [DW-1:0] step;
  logic          valid;
  logic [CHW-1:0] ch;
  logic [DW-1:0] data;

  adc_stim_gen #(
    .DATA_W(DW), .NUM_CH(NCH), .PERIOD_CYCLES(P), .NOISE_W(NW), .BASE(12'h8C0)
  ) dut (
    .MAX10_CLK1_50       (clk),
    .reset_n             (reset_n),
    .enable              (enable),
    .mode                (mode),
    .step                (step),
    .response_valid_out  (valid),
    .response_channel_out(ch),
    .ADC_out             (data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Sample k since reset goes to channel k mod NUM_CH with noise counter k mod 2^NW.
  int           m_cnt;
  int           m_acc [NCH];
  int           m_lfsr;
  logic [63:0]  exp_q[$];

  task automatic model_reset();
    m_cnt  = 0;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < NCH; i++) m_acc[i] = 0;
  endtask

  task automatic push_exp(input int m, input int st, input int at_cyc);
    int c, v, fb;
    c = m_cnt % NCH;
    case (m)
      0: v = BASE_CLR | (m_cnt % 32);
      1: begin m_acc[c] = (m_acc[c] + st) % 4096; v = m_acc[c]; end
      2: v = BASE_CLR | (m_lfsr % 32);
      default: v = BASE_CLR | (c % 32);
    endcase
    m_cnt++;
    fb = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
    m_lfsr = (m_lfsr >> 1) | (fb << 15);
    exp_q.push_back({32'(at_cyc), 16'(c), 16'(v)});
  endtask

  // ---------------- driver tasks (entered #1 after a posedge) ----------------
  task automatic one_sample(input int m, input int st);
    mode = 2'(m);
    step = DW'(st);
    push_exp(m, st, cyc + P);
    repeat (P) @(posedge clk);
    #1;
  endtask

  // Junk mode/step for most of the period; the real values arrive late.
  task automatic rand_sample();
    int m, st, start;
    start = cyc;
    mode = 2'($urandom_range(0, 3));
    step = DW'($urandom_range(0, 4095));
    repeat (P - 3) @(posedge clk);
    #1;
    m  = $urandom_range(0, 3);
    st = $urandom_range(0, 4095);
    mode = 2'(m);
    step = DW'(st);
    push_exp(m, st, start + P);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [DW-1:0]  last_data = '0;
  logic [CHW-1:0] last_ch   = '0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset_n) begin
      last_data = '0;
      last_ch   = '0;
    end else if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: actual ch=%0d data=%h at cyc=%0d, required no strobe", ch, data, cyc);
      end else begin
        e = exp_q.pop_front();
        check_val("strobe_data", int'(data), int'(e[15:0]));
        check_val("strobe_ch",   int'(ch),   int'(e[31:16]));
        check_val("strobe_cyc",  cyc,        int'(e[63:32]));
      end
      last_data = data;
      last_ch   = ch;
    end else begin
      checks++;
      if (data !== last_data || ch !== last_ch) begin
        errors++;
        $display("FAIL hold: actual ch=%0d data=%h, required ch=%0d data=%h at cyc=%0d",
                 ch, data, last_ch, last_data, cyc);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    mode    = 2'd0;
    step    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_valid", int'(valid), 0);
    check_val("reset_ch",    int'(ch),    0);
    check_val("reset_data",  int'(data),  0);
    reset_n = 1'b1;
    enable  = 1'b1;

    // COUNT: 33 samples, noise field wraps 31 -> 0.
    for (int i = 0; i < 33; i++) one_sample(0, 0);

    // RAMP step 0x400 for four rounds, then step 1.
    for (int i = 0; i < 16; i++) one_sample(1, 12'h400);
    for (int i = 0; i < 4; i++)  one_sample(1, 1);

    // Enable gap mid-period: no strobe during gap, full period after re-enable.
    mode = 2'd0;
    repeat (10) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    enable = 1'b1;
    one_sample(0, 0);
    one_sample(3, 0);

    // Enable dropped exactly on the would-be emit edge.
    repeat (P - 1) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b1;
    one_sample(0, 0);

    // Asynchronous reset during a strobe cycle.
    mode = 2'd0;
    repeat (P) @(posedge clk);
    #1;
    check_val("rst_pre_valid", int'(valid), 1);
    reset_n = 1'b0;
    #1;
    check_val("rst_async_valid", int'(valid), 0);
    check_val("rst_async_ch",    int'(ch),    0);
    check_val("rst_async_data",  int'(data),  0);
    enable = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    enable  = 1'b1;

    // LFSR from seed: 100 samples.
    for (int i = 0; i < 100; i++) one_sample(2, 0);

    // Random mode/step with late-arriving values.
    for (int i = 0; i < 40; i++) rand_sample();

    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
